// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Walks K x K convolution windows over an IMG_W x IMG_H image held in a
//   single-port memory. Output positions go in raster order. Inside a window
//   the kernel column offset (kc) steps fastest, then the kernel row (kr).
//   Only one memory read is in flight at a time. Each fetched pixel is then
//   offered on a valid/ready stream, with window-first/last tags and the
//   output coordinate of its window.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high; clears every output
//   start      : one-cycle frame request, accepted only in IDLE
//   busy       : high from the cycle after start until the done cycle
//   done       : one-cycle pulse after the final pixel handshake
//   mem_re     : memory read enable (one cycle per pixel)
//   mem_addr   : read address, valid while mem_re is high
//   mem_rdata  : read data, arrives one cycle after mem_re
//   pix_data   : pixel presented to the datapath
//   pix_valid  : pix_data valid
//   pix_ready  : datapath accepts when pix_valid && pix_ready
//   win_first  : pixel is kernel offset (0,0)
//   win_last   : pixel is kernel offset (K-1,K-1)
//   out_row    : output row of the window being streamed
//   out_col    : output column of the window being streamed
module conv_window_sequencer #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 640,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int ADDR_W = 25,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              win_first,
   output logic              win_last,
   output logic [15:0]       out_row,
   output logic [15:0]       out_col
);

   localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
   localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE} state_t;

   state_t              state_q;
   logic                busy_q, done_q, mem_re_q, pix_valid_q;
   logic                win_first_q, win_last_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   pix_data_q;
   logic [15:0]         out_row_q, out_col_q;

   // Walk position: kernel offset inside the window and the window's output coordinate
   logic [3:0]          kc_q, kr_q;
   logic [15:0]         col_q, row_q;

   logic [3:0]          kc_d, kr_d;
   logic [15:0]         col_d, row_d;
   logic                kc_last, kr_last, col_last, row_last, frame_last;
   logic [ADDR_W-1:0]   nxt_addr;

   function automatic logic [ADDR_W-1:0] calc_addr(input logic [15:0] r, input logic [15:0] c,
                                                   input logic [3:0] kr, input logic [3:0] kc);
      logic [ADDR_W-1:0] img_r, img_c;
      img_r = ADDR_W'(r) * ADDR_W'(STRIDE) + ADDR_W'(kr);
      img_c = ADDR_W'(c) * ADDR_W'(STRIDE) + ADDR_W'(kc);
      return img_r * ADDR_W'(IMG_W) + img_c;
   endfunction

   // Next walk position (taken on a handshake) and the address it points at
   always_comb begin
      kc_last    = (kc_q == 4'(K - 1));
      kr_last    = (kr_q == 4'(K - 1));
      col_last   = (col_q == 16'(OUT_W - 1));
      row_last   = (row_q == 16'(OUT_H - 1));
      frame_last = kc_last && kr_last && col_last && row_last;
      kc_d  = kc_q;
      kr_d  = kr_q;
      col_d = col_q;
      row_d = row_q;
      if (!kc_last) begin
         kc_d = kc_q + 4'd1;
      end else begin
         kc_d = 4'd0;
         if (!kr_last) begin
            kr_d = kr_q + 4'd1;
         end else begin
            kr_d = 4'd0;
            if (!col_last) begin
               col_d = col_q + 16'd1;
            end else begin
               col_d = 16'd0;
               row_d = row_q + 16'd1;
            end
         end
      end
      nxt_addr = calc_addr(row_d, col_d, kr_d, kc_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         win_first_q <= 1'b0;
         win_last_q  <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         kc_q        <= '0;
         kr_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
      end else begin
         // done and mem_re are single-cycle strobes unless re-armed below
         done_q   <= 1'b0;
         mem_re_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= FETCH;
                  busy_q     <= 1'b1;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= '0;
                  kc_q       <= '0;
                  kr_q       <= '0;
                  col_q      <= '0;
                  row_q      <= '0;
               end
            end
            FETCH: state_q <= WAIT;
            WAIT: begin
               // Read data lands now; tags and coordinates are latched with it
               pix_data_q  <= mem_rdata;
               pix_valid_q <= 1'b1;
               win_first_q <= (kc_q == 4'd0) && (kr_q == 4'd0);
               win_last_q  <= kc_last && kr_last;
               out_row_q   <= row_q;
               out_col_q   <= col_q;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (pix_ready) begin
                  pix_valid_q <= 1'b0;
                  kc_q        <= kc_d;
                  kr_q        <= kr_d;
                  col_q       <= col_d;
                  row_q       <= row_d;
                  if (frame_last) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= FETCH;
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= nxt_addr;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_re    = mem_re_q;
   assign mem_addr  = mem_addr_q;
   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;
   assign win_first = win_first_q;
   assign win_last  = win_last_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;

endmodule
